// File: rtl/aes_inv_key_expand.sv
// ============================================================================
// Module   : aes_inv_key_expand
// Purpose  : Iterative AES-128 reverse key schedule. Loads the round-10 key
//            and emits round keys 10 down to 0, one per valid/ready transfer.
//            Each step derives the previous round key using a single S-box
//            word (RotWord before SubWord) plus XORs.
//            Optional macro INVKEY_STORE_EN adds an 11-entry key store with
//            a registered read port (rd_round -> rd_key).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Four-byte AES S-box word substitution (purely combinational).
module aes_sbox_word (
    input  logic [31:0] word,
    output logic [31:0] sub_word
);
    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // One table lookup per byte lane
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign sub_word[8*i +: 8] = c_SBOX[word[8*i +: 8]];
    end
endmodule

module aes_inv_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t         r_state;
    logic [127:0]   r_key;
    logic [3:0]     r_round;
    logic           r_valid;
    logic           r_busy;
    logic           r_done;

    logic           w_accept;
    logic           w_xfer;
    logic [31:0]    w_k0, w_k1, w_k2, w_k3;
    logic [31:0]    w_p0, w_p1, w_p2, w_p3;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [7:0]     w_rcon;
    logic [127:0]   w_prev_key;

    // A start coinciding with the done pulse is deliberately not accepted
    assign w_accept = (r_state == ST_IDLE) && start && !r_done;
    assign w_xfer   = (r_state == ST_EMIT) && rk_ready;

    assign {w_k0, w_k1, w_k2, w_k3} = r_key;

    // Undo the forward-schedule XOR chain; only p0 needs the non-linear word
    assign w_p3  = w_k3 ^ w_k2;
    assign w_p2  = w_k2 ^ w_k1;
    assign w_p1  = w_k1 ^ w_k0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    aes_sbox_word u_sbox (
        .word     (w_rot),
        .sub_word (w_sub)
    );

    // Round-constant ROM indexed by the current round number
    always_comb begin
        w_rcon = 8'h00;
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_p0       = w_k0 ^ w_sub ^ {w_rcon, 24'h0};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    // Control FSM with registered outputs; key register steps back one round per transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_key   <= key_last;
                        r_round <= 4'd10;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        if (r_round != 4'd0) begin
                            r_key   <= w_prev_key;
                            r_round <= r_round - 4'd1;
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign rk_valid = r_valid;
    assign rk_round = r_round;
    assign rk_out   = r_key;
    assign done     = r_done;

`ifdef INVKEY_STORE_EN
    logic [127:0] r_store [11];
    logic [10:0]  r_stored;
    logic [127:0] r_rd_key;

    // Capture each emitted key at its transfer; the payload needs no reset
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_store[r_round] <= r_key;
        end
    end

    // Per-entry valid bits plus registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stored <= '0;
            r_rd_key <= '0;
        end else begin
            if (w_accept) begin
                r_stored <= '0;
            end else if (w_xfer) begin
                r_stored[r_round] <= 1'b1;
            end
            if ((rd_round <= 4'd10) && r_stored[rd_round]) begin
                r_rd_key <= r_store[rd_round];
            end else begin
                r_rd_key <= '0;
            end
        end
    end

    assign rd_key = r_rd_key;
`else
    logic w_unused_rd;

    assign w_unused_rd = ^rd_round;
    assign rd_key      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_expand.sv
`default_nettype none

module tb_aes_inv_key_expand;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_last = '0;
    logic         rk_ready = 1'b0;
    logic [3:0]   rd_round = '0;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_round;
    logic [127:0] rk_out, rd_key;

    int n_cmp  = 0;
    int n_fail = 0;

    // Sequence capture filled by the run driver
    logic [127:0] got_key [11];
    int           seq_cycles;
    bit           seq_timeout;
    int           seq_order_err;
    int           seq_hold_err;
    int           seq_stall_seen;

    // FIPS-197 Appendix A.1 round keys, index = round
    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    aes_inv_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_last (key_last),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk_out   (rk_out),
        .done     (done),
        .rd_round (rd_round),
        .rd_key   (rd_key)
    );

    always #5 clk = ~clk;

    // Forward AES-128 key expansion: round-r key from the round-0 key
    function automatic logic [127:0] fwd_key(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int i = 1; i <= r; i++) begin
            t  = {w3[23:0], w3[31:24]};
            t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
        end
        return {w0, w1, w2, w3};
    endfunction

    // Starts a run and drains it; optional stall and start-while-busy injection
    task automatic run_seq(input logic [127:0] k, input int stall_round, input int stall_n,
                           input int busy_round);
        int           cyc;
        int           stalled;
        int           exp_round;
        bit           pulsed;
        logic [127:0] hold_key;
        for (int i = 0; i < 11; i++) got_key[i] = '0;
        seq_order_err  = 0;
        seq_hold_err   = 0;
        seq_stall_seen = 0;
        stalled        = 0;
        exp_round      = 10;
        pulsed         = 1'b0;
        hold_key       = '0;
        repeat (2) @(negedge clk);
        key_last = k;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        key_last = ~k;
        cyc      = 1;
        while (!done && cyc < 40) begin
            start    = 1'b0;
            rk_ready = 1'b1;
            if (rk_valid) begin
                if (int'(rk_round) == stall_round && stalled < stall_n) begin
                    if (stalled == 0) hold_key = rk_out;
                    else if (rk_out !== hold_key) seq_hold_err++;
                    rk_ready = 1'b0;
                    stalled++;
                    seq_stall_seen++;
                end else begin
                    if (stalled > 0 && int'(rk_round) == stall_round && rk_out !== hold_key)
                        seq_hold_err++;
                    if (int'(rk_round) != exp_round) seq_order_err++;
                    if (rk_round <= 4'd10) got_key[rk_round] = rk_out;
                    exp_round--;
                end
                if (int'(rk_round) == busy_round && !pulsed) begin
                    start    = 1'b1;
                    key_last = k ^ 128'h5555_aaaa_0000_ffff_1234_5678_9abc_def0;
                    pulsed   = 1'b1;
                end
            end else begin
                seq_order_err++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start       = 1'b0;
        rk_ready    = 1'b1;
        seq_cycles  = cyc;
        seq_timeout = (done !== 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid: got %b expected 0", rk_valid); end
        n_cmp++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL reset_rk_round: got %0d expected 0", rk_round); end
        n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL reset_rk_out: got %h expected 0", rk_out); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        run_seq(FIPS_RK[10], -1, 0, -1);
        n_cmp++; if (seq_timeout) begin n_fail++; $display("FAIL fips_timeout: got no done expected done"); end
        n_cmp++; if (seq_cycles != 12) begin n_fail++; $display("FAIL fips_latency: got %0d expected 12", seq_cycles); end
        n_cmp++; if (seq_order_err != 0) begin n_fail++; $display("FAIL fips_order: got %0d errors expected 0", seq_order_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fips_busy_at_done: got %b expected 0", busy); end
        for (int r = 0; r <= 10; r++) begin
            n_cmp++;
            if (got_key[r] !== FIPS_RK[r]) begin
                n_fail++; $display("FAIL fips_rk%0d: got %h expected %h", r, got_key[r], FIPS_RK[r]);
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_store();
        logic [127:0] exp0, exp10;
`ifdef INVKEY_STORE_EN
        exp0  = FIPS_RK[0];
        exp10 = FIPS_RK[10];
`else
        exp0  = '0;
        exp10 = '0;
`endif
        rd_round = 4'd0;
        @(posedge clk); #1;
        n_cmp++; if (rd_key !== exp0) begin n_fail++; $display("FAIL store_rd0: got %h expected %h", rd_key, exp0); end
        rd_round = 4'd11;
        @(posedge clk); #1;
        n_cmp++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL store_rd11: got %h expected 0", rd_key); end
        rd_round = 4'd10;
        @(posedge clk); #1;
        n_cmp++; if (rd_key !== exp10) begin n_fail++; $display("FAIL store_rd10: got %h expected %h", rd_key, exp10); end
    endtask

    task automatic test_backpressure();
        run_seq(FIPS_RK[10], 5, 3, -1);
        n_cmp++; if (seq_timeout) begin n_fail++; $display("FAIL bp_timeout: got no done expected done"); end
        n_cmp++; if (seq_cycles != 15) begin n_fail++; $display("FAIL bp_latency: got %0d expected 15", seq_cycles); end
        n_cmp++; if (seq_stall_seen != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 3", seq_stall_seen); end
        n_cmp++; if (seq_hold_err != 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes expected 0", seq_hold_err); end
        n_cmp++; if (seq_order_err != 0) begin n_fail++; $display("FAIL bp_order: got %0d errors expected 0", seq_order_err); end
        for (int r = 0; r <= 10; r++) begin
            n_cmp++;
            if (got_key[r] !== FIPS_RK[r]) begin
                n_fail++; $display("FAIL bp_rk%0d: got %h expected %h", r, got_key[r], FIPS_RK[r]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_seq(FIPS_RK[10], -1, 0, 7);
        n_cmp++; if (seq_cycles != 12) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 12", seq_cycles); end
        n_cmp++; if (seq_order_err != 0) begin n_fail++; $display("FAIL busy_start_order: got %0d errors expected 0", seq_order_err); end
        for (int r = 0; r <= 10; r++) begin
            n_cmp++;
            if (got_key[r] !== FIPS_RK[r]) begin
                n_fail++; $display("FAIL busy_start_rk%0d: got %h expected %h", r, got_key[r], FIPS_RK[r]);
            end
        end
    endtask

    task automatic test_zero_key();
        logic [127:0] exp_k;
        run_seq(128'h0, -1, 0, -1);
        n_cmp++; if (seq_cycles != 12) begin n_fail++; $display("FAIL zero_latency: got %0d expected 12", seq_cycles); end
        n_cmp++; if (got_key[10] !== 128'h0) begin n_fail++; $display("FAIL zero_rk10: got %h expected 0", got_key[10]); end
        n_cmp++;
        if (got_key[9] !== {32'h55636363, 96'h0}) begin
            n_fail++; $display("FAIL zero_rk9: got %h expected %h", got_key[9], {32'h55636363, 96'h0});
        end
        for (int r = 0; r <= 10; r++) begin
            exp_k = fwd_key(got_key[0], r);
            n_cmp++;
            if (got_key[r] !== exp_k) begin
                n_fail++; $display("FAIL zero_fwd_rk%0d: got %h expected %h", r, got_key[r], exp_k);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        repeat (2) @(negedge clk);
        key_last = FIPS_RK[10];
        start    = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(rk_valid === 1'b1 && rk_round === 4'd4) && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++; if (!(rk_valid === 1'b1 && rk_round === 4'd4)) begin n_fail++; $display("FAIL rstmid_reach_r4: got round %0d expected 4", rk_round); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_cmp++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rk_valid: got %b expected 0", rk_valid); end
        n_cmp++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL rstmid_rk_round: got %0d expected 0", rk_round); end
        n_cmp++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL rstmid_rk_out: got %h expected 0", rk_out); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
        rd_round = 4'd10;
        @(posedge clk); #1;
        n_cmp++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL rstmid_store_cleared: got %h expected 0", rd_key); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b expected 0", done); end
        run_seq(FIPS_RK[10], -1, 0, -1);
        n_cmp++; if (seq_cycles != 12) begin n_fail++; $display("FAIL rstmid_rerun_latency: got %0d expected 12", seq_cycles); end
        for (int r = 0; r <= 10; r++) begin
            n_cmp++;
            if (got_key[r] !== FIPS_RK[r]) begin
                n_fail++; $display("FAIL rstmid_rerun_rk%0d: got %h expected %h", r, got_key[r], FIPS_RK[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_store();
        test_backpressure();
        test_start_while_busy();
        test_zero_key();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
